seq_selection_sorter: RTL and testbench

- Clocked, handshaked selection-sort engine: accepts N words serially, sorts them in place, then streams them out in order.
- One compare per cycle, so area stays small.
- Sits between a producer and consumer stream: the load side is the writer into the sort buffer, the unload side is the reader out of it.
- Sorted result is bit-identical to the existing combinational selection_sort for the same N and WIDTH with DESCEND=0.

---
 rtl/seq_selection_sorter.sv | 138 +++++++++++++
 tb/tb_seq_selection_sorter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_selection_sorter.sv
// seq_selection_sorter
//   Handshaked selection-sort engine. Loads N words serially, sorts them in
//   place with one compare per cycle, then streams them out in order.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   in_data valid          in_ready   element accepted this cycle
//     in_data    element to load
//     out_valid  out_data valid         out_ready  consumer takes out_data
//     out_data   sorted element         out_last   final element of the batch
//     busy       sorting or unloading
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_LOAD    | accepting elements into mem[cnt]
//   S_COMPARE | scan mem[j] against the current extreme mem[min_idx]
//   S_SWAP    | exchange mem[i] with mem[min_idx], advance the outer pass
//   S_UNLOAD  | presenting mem[cnt] to the consumer
module seq_selection_sorter #(
  parameter int N       = 5,
  parameter int WIDTH   = 8,
  parameter int DESCEND = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW-1:0] PEN  = IW'(N - 2);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPARE = 2'd1,
    S_SWAP    = 2'd2,
    S_UNLOAD  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mem [N];
  logic [IW-1:0]    cnt, i, j, min_idx;
  logic             take_j;

  // Strict compare: equal keys keep the earlier index, matching the
  // combinational reference sorter.
  assign take_j = (DESCEND != 0) ? (mem[j] > mem[min_idx])
                                 : (mem[j] < mem[min_idx]);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b1;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && cnt == LAST) state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        if (j == LAST) state_nxt = S_SWAP;
      end
      S_SWAP: begin
        state_nxt = (i == PEN) ? S_UNLOAD : S_COMPARE;
      end
      S_UNLOAD: begin
        out_valid = 1'b1;
        out_data  = mem[cnt];
        out_last  = (cnt == LAST);
        if (out_ready && cnt == LAST) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_LOAD;
      cnt     <= '0;
      i       <= '0;
      j       <= '0;
      min_idx <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            if (cnt == LAST) begin
              cnt     <= '0;
              i       <= '0;
              j       <= IW'(1);
              min_idx <= '0;
            end else begin
              cnt <= cnt + IW'(1);
            end
          end
        end
        S_COMPARE: begin
          if (take_j) min_idx <= j;
          if (j != LAST) j <= j + IW'(1);
        end
        S_SWAP: begin
          if (i != PEN) begin
            i       <= i + IW'(1);
            min_idx <= i + IW'(1);
            j       <= i + IW'(2);
          end
        end
        S_UNLOAD: begin
          if (out_ready) cnt <= (cnt == LAST) ? '0 : cnt + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Buffer is deliberately not reset; contents are meaningless after an abort.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid) mem[cnt] <= in_data;
    if (state == S_SWAP) begin
      mem[i]       <= mem[min_idx];
      mem[min_idx] <= mem[i];
    end
  end

endmodule

// File: tb/tb_seq_selection_sorter.sv
// Testbench for seq_selection_sorter: ascending and descending N=5 units share
// stimulus; a separate N=8, WIDTH=16 unit is checked against a sorted queue.
module tb_seq_selection_sorter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid, out_ready;
  logic [7:0] in_data;
  logic       a_in_ready, a_out_valid, a_out_last, a_busy;
  logic [7:0] a_out_data;
  logic       b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [7:0] b_out_data;

  logic        w_in_valid, w_out_ready;
  logic [15:0] w_in_data, w_out_data;
  logic        w_in_ready, w_out_valid, w_out_last, w_busy;

  seq_selection_sorter #(.N(5), .WIDTH(8), .DESCEND(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy));

  seq_selection_sorter #(.N(5), .WIDTH(8), .DESCEND(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy));

  seq_selection_sorter #(.N(8), .WIDTH(16), .DESCEND(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_data(w_in_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_data(w_out_data), .out_last(w_out_last), .busy(w_busy));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [4:0][7:0] din;
    logic [4:0][7:0] dout;
    logic            gaps;
    logic            stall;
    logic            junk;
  } vec_t;

  function automatic logic [4:0][7:0] mk(input logic [7:0] a, b, c, d, e);
    logic [4:0][7:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e;
    return r;
  endfunction

  // out_ready pattern 1,0,0,1,0,1 (bit 0 first)
  logic [5:0] stall_pat = 6'b101001;

  task automatic run_batch(input logic [4:0][7:0] din, input logic [4:0][7:0] dout,
                           input logic gaps, input logic stall, input logic junk);
    int k, c, n;
    k = 0; c = 0;
    while (k < 5 && c < 100) begin
      @(negedge clk);
      c++;
      chk("load_in_ready", {31'd0, a_in_ready}, 1);
      chk("load_busy", {31'd0, a_busy}, 0);
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? din[k] : 8'($urandom);
      if (in_valid && a_in_ready) k++;
    end
    chk("load_count", k, 5);
    @(negedge clk);
    in_valid = junk;
    in_data  = 8'($urandom);
    n = 0;
    while (a_busy && !a_out_valid && n < 100) begin
      chk("sort_in_ready", {31'd0, a_in_ready}, 0);
      n++;
      @(negedge clk);
      in_data = 8'($urandom);
    end
    chk("sort_len", n, 14);
    k = 0; c = 0;
    while (k < 5 && c < 200) begin
      out_ready = stall ? stall_pat[c % 6] : 1'b1;
      in_valid  = junk;
      in_data   = 8'($urandom);
      chk("out_valid", {31'd0, a_out_valid}, 1);
      chk("out_data", {24'd0, a_out_data}, {24'd0, dout[k]});
      chk("out_last", {31'd0, a_out_last}, {31'd0, k == 4});
      chk("unload_in_ready", {31'd0, a_in_ready}, 0);
      chk("unload_busy", {31'd0, a_busy}, 1);
      chk("desc_out_data", {24'd0, b_out_data}, {24'd0, dout[4-k]});
      chk("desc_out_last", {31'd0, b_out_last}, {31'd0, k == 4});
      if (out_ready && a_out_valid) k++;
      c++;
      @(negedge clk);
    end
    chk("unload_count", k, 5);
    if (!stall) chk("unload_len", c, 5);
    chk("post_in_ready", {31'd0, a_in_ready}, 1);
    chk("post_out_valid", {31'd0, a_out_valid}, 0);
    chk("post_busy", {31'd0, a_busy}, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic run_wide(input int b);
    logic [15:0] q[$];
    logic [15:0] e[$];
    int k, c, n;
    q = {};
    for (int m = 0; m < 8; m++)
      q.push_back((b % 3 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom));
    e = q;
    e.sort();
    k = 0; c = 0;
    while (k < 8 && c < 200) begin
      @(negedge clk);
      c++;
      w_in_valid = ($urandom_range(0, 3) != 0);
      w_in_data  = w_in_valid ? q[k] : 16'($urandom);
      if (w_in_valid && w_in_ready) k++;
    end
    chk("w_load_count", k, 8);
    @(negedge clk);
    w_in_valid = 1'b1;
    w_in_data  = 16'($urandom);
    n = 0;
    while (w_busy && !w_out_valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("w_sort_len", n, 35);
    k = 0; c = 0;
    while (k < 8 && c < 400) begin
      w_out_ready = 1'($urandom_range(0, 1));
      chk("w_out_valid", {31'd0, w_out_valid}, 1);
      chk("w_out_data", {16'd0, w_out_data}, {16'd0, e[k]});
      chk("w_out_last", {31'd0, w_out_last}, {31'd0, k == 7});
      if (w_out_ready && w_out_valid) k++;
      c++;
      @(negedge clk);
    end
    chk("w_unload_count", k, 8);
    chk("w_post_in_ready", {31'd0, w_in_ready}, 1);
    chk("w_post_out_valid", {31'd0, w_out_valid}, 0);
    w_in_valid  = 1'b0;
    w_out_ready = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    logic [7:0] r[$];
    logic [4:0][7:0] din, dout;

    vecs[0] = '{din: mk(30,10,50,20,40),   dout: mk(10,20,30,40,50),   gaps: 0, stall: 0, junk: 0};
    vecs[1] = '{din: mk(7,3,7,3,0),        dout: mk(0,3,3,7,7),        gaps: 0, stall: 0, junk: 0};
    vecs[2] = '{din: mk(1,2,3,4,5),        dout: mk(1,2,3,4,5),        gaps: 0, stall: 0, junk: 0};
    vecs[3] = '{din: mk(5,4,3,2,1),        dout: mk(1,2,3,4,5),        gaps: 0, stall: 0, junk: 0};
    vecs[4] = '{din: mk(255,0,255,0,128),  dout: mk(0,0,128,255,255),  gaps: 0, stall: 0, junk: 0};
    vecs[5] = '{din: mk(30,10,50,20,40),   dout: mk(10,20,30,40,50),   gaps: 0, stall: 1, junk: 0};
    vecs[6] = '{din: mk(7,3,7,3,0),        dout: mk(0,3,3,7,7),        gaps: 1, stall: 0, junk: 0};
    vecs[7] = '{din: mk(30,10,50,20,40),   dout: mk(10,20,30,40,50),   gaps: 0, stall: 0, junk: 1};

    in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_data = 16'd0; w_out_ready = 1'b0;

    #1;
    chk("rst_in_ready", {31'd0, a_in_ready}, 1);
    chk("rst_out_valid", {31'd0, a_out_valid}, 0);
    chk("rst_out_last", {31'd0, a_out_last}, 0);
    chk("rst_out_data", {24'd0, a_out_data}, 0);
    chk("rst_busy", {31'd0, a_busy}, 0);
    chk("rst_w_out_data", {16'd0, w_out_data}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++)
      run_batch(vecs[v].din, vecs[v].dout, vecs[v].gaps, vecs[v].stall, vecs[v].junk);

    // Abort during the 6th sort cycle, then a clean batch.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vecs[0].din[k];
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_pre_busy", {31'd0, a_busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, a_in_ready}, 1);
    chk("abort_busy", {31'd0, a_busy}, 0);
    chk("abort_out_valid", {31'd0, a_out_valid}, 0);
    chk("abort_out_data", {24'd0, a_out_data}, 0);
    chk("abort_out_last", {31'd0, a_out_last}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("abort_no_out_valid", {31'd0, a_out_valid}, 0);
    end
    run_batch(mk(9,8,7,6,5), mk(5,6,7,8,9), 0, 0, 0);

    // Random 5-element batches against a sorted-queue model.
    for (int b = 0; b < 20; b++) begin
      r = {};
      for (int k = 0; k < 5; k++) begin
        din[k] = (b % 4 == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
        r.push_back(din[k]);
      end
      r.sort();
      for (int k = 0; k < 5; k++) dout[k] = r[k];
      run_batch(din, dout, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end

    for (int b = 0; b < 100; b++) run_wide(b);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
